multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, the maximum memory wait in cycles; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports opcode  input  7  (IR[6:0]); bcond  input  1  (ALU branch result); halt_req  input  1  (ecall halt condition); mem_ready  input  1  (memory access complete).
REQ-006 SHALL have ports mem_read, mem_write, iord, ir_write, reg_write, pc_write  output  1 each  (iord: 0=PC address, 1=ALUOut address).
REQ-007 SHALL have ports alu_src_a  output  2  (00 PC, 01 rs1, 10 zero); alu_src_b  output  2  (00 rs2, 01 imm); alu_ctrl_sel  output  2  (00 add, 01 funct-decoded, 10 branch compare).
REQ-008 SHALL have ports pc_source  output  2  (00 PC+4, 01 ALUOut, 10 ALU result); wb_sel  output  2  (00 ALUOut, 01 MDR, 10 PC+4).
REQ-009 SHALL have ports is_halted  output  1;  error  output  1;  state  output  4  (debug);  instret  output  CNT_W.

Function
REQ-010 SHALL implement the states IF, ID, EX_R, EX_I, EX_LUI, EX_ADDR, EX_BR, JAL, JALR, MEM_RD, MEM_WR, WB_ALU, WB_LD, HALT and ERR.
REQ-011 SHALL drive all outputs combinationally from the state, from bcond in EX_BR and from mem_ready in the wait states, and SHALL drive every output not listed for a state to 0.
REQ-012 IF: mem_read=1, iord=0; the block SHALL hold in IF until mem_ready=1, then assert ir_write=1 and move to ID.
REQ-013 ID: alu_src_a=00, alu_src_b=01, alu_ctrl_sel=00, so that ALUOut captures PC+imm.
REQ-014 ID next-state decode SHALL be: 0110011->EX_R; 0010011->EX_I; 0000011 and 0100011->EX_ADDR; 1100011->EX_BR; 1101111->JAL; 1100111->JALR; 0110111->EX_LUI; 0010111->WB_ALU; any other opcode->ERR.
REQ-015 For ID with opcode 1110011: halt_req=1 SHALL give HALT; otherwise ID SHALL assert pc_write=1 with pc_source=00 and move to IF.
REQ-016 EX_R SHALL drive a=01, b=00, alu_ctrl_sel=01; EX_I SHALL drive a=01, b=01, alu_ctrl_sel=01; EX_LUI SHALL drive a=10, b=01, alu_ctrl_sel=00; each SHALL move to WB_ALU.
REQ-017 EX_ADDR SHALL drive a=01, b=01, alu_ctrl_sel=00, then move to MEM_RD for a load or MEM_WR for a store.
REQ-018 MEM_RD SHALL drive mem_read=1, iord=1 and wait for mem_ready, then move to WB_LD; MEM_WR SHALL drive mem_write=1, iord=1 and wait for mem_ready, and on mem_ready SHALL assert pc_write=1 with pc_source=00 and move to IF.
REQ-019 WB_ALU and WB_LD SHALL assert reg_write=1 with wb_sel=00 or 01 respectively, plus pc_write=1 with pc_source=00, then move to IF.
REQ-020 EX_BR SHALL drive a=01, b=00, alu_ctrl_sel=10 and pc_write=1, with pc_source=01 when bcond=1 and 00 otherwise, then move to IF.
REQ-021 JAL SHALL assert reg_write=1, wb_sel=10, pc_write=1, pc_source=01, then move to IF.
REQ-022 JALR SHALL drive a=01, b=01, alu_ctrl_sel=00 and assert reg_write=1, wb_sel=10, pc_write=1, pc_source=10, then move to IF.
REQ-023 instret SHALL increment by 1 in every cycle with pc_write=1 and SHALL wrap modulo 2^CNT_W.
REQ-024 The wait counter SHALL clear on entry to IF, MEM_RD or MEM_WR and SHALL increment each cycle the block waits there with mem_ready=0.
REQ-025 When MEM_TIMEOUT>0 and the wait count reaches MEM_TIMEOUT with mem_ready=0, the block SHALL go to ERR; mem_ready=1 in that same cycle SHALL take priority over the timeout.
REQ-026 mem_ready SHALL be ignored in every state except IF, MEM_RD and MEM_WR.
REQ-027 HALT and ERR SHALL be absorbing until reset; is_halted=1 in both; error=1 only in ERR; no strobes SHALL be asserted in either.

Reset
REQ-028 While reset=0 at a rising edge, the block SHALL load state=IF, instret=0 and wait counter=0, taking priority over any transition.
REQ-029 While reset=0, all strobe outputs SHALL be forced to 0, and is_halted and error SHALL be 0.
REQ-030 Reset asserted mid-operation, including during a memory wait, SHALL abort the instruction with no pc_write or reg_write.

Structure
REQ-031 A shared package SHALL hold the state enum, the opcode constants, and the alu_src_a, alu_src_b, alu_ctrl_sel, pc_source and wb_sel encodings.
REQ-032 The wait/timeout counter SHALL be a separate sub-module named mem_wait_timer.

Verification
REQ-033 The bench SHALL cover: add (0110011) with mem_ready always 1 -> states IF,ID,EX_R,WB_ALU; reg_write in cycle 4; instret=1.
REQ-034 The bench SHALL cover: lw with mem_ready delayed 3 cycles in MEM_RD -> 7 cycles total; wb_sel=01 in WB_LD.
REQ-035 The bench SHALL cover: beq with bcond=1 -> pc_source=01, and with bcond=0 -> pc_source=00; both take 3 cycles.
REQ-036 The bench SHALL cover: MEM_TIMEOUT=4 with mem_ready held at 0 in IF -> ERR after 4 wait cycles, error=1, is_halted=1; mem_ready=1 on the 4th wait cycle -> ID.
REQ-037 The bench SHALL cover: ecall with halt_req=1 -> HALT held for 10 cycles; reset=0 for one edge -> IF, instret=0.
REQ-038 The bench SHALL cover: CNT_W=4 with 17 instructions retired -> instret=1; opcode 1111111 -> ERR.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// RV32 opcode constants and the encodings of every datapath select field.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_LUI  = 4'd4,
        S_EX_ADDR = 4'd5,
        S_EX_BR   = 4'd6,
        S_JAL     = 4'd7,
        S_JALR    = 4'd8,
        S_MEM_RD  = 4'd9,
        S_MEM_WR  = 4'd10,
        S_WB_ALU  = 4'd11,
        S_WB_LD   = 4'd12,
        S_HALT    = 4'd13,
        S_ERR     = 4'd14
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_RS1  = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] SRC_B_RS2 = 2'b00;
    localparam logic [1:0] SRC_B_IMM = 2'b01;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_BRANCH = 2'b10;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_ALU    = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    // States in which the controller waits on the memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts consecutive cycles spent waiting on mem_ready
// and flags the cycle in which the wait would reach MEM_TIMEOUT.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   active      - controller is in a memory wait state
//   mem_ready   - memory handshake
//   timeout     - this cycle is the MEM_TIMEOUT-th wait cycle (mem_ready=0)
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int TW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] LAST = TW'(LAST_I);

    logic [TW-1:0] count;

    // Any cycle not spent waiting clears the count, so it is always zero
    // on entry to a wait state. The count never passes LAST because the
    // timeout moves the controller out of the wait state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (active && !mem_ready && (MEM_TIMEOUT != 0)) begin
            count <= count + TW'(1);
        end else begin
            count <= '0;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit. Sequences fetch, decode, execute, memory
// and write-back, driving the datapath strobes and selects as a function of
// the current state (plus bcond in EX_BR and mem_ready in wait states).
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   opcode, bcond       - IR[6:0] and ALU branch outcome
//   halt_req, mem_ready - ecall halt condition, memory access complete
//   mem_read .. pc_write- datapath strobes (iord: 0=PC, 1=ALUOut address)
//   alu_src_a/b, alu_ctrl_sel, pc_source, wb_sel - datapath selects
//   is_halted, error    - HALT/ERR status
//   state, instret      - debug state and retired-instruction counter
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_ctrl_sel,
    output logic [1:0]       pc_source,
    output logic [1:0]       wb_sel,
    output logic             is_halted,
    output logic             error,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    state_t cur;
    state_t nxt;
    logic   wait_active;
    logic   timeout;

    assign state       = cur;
    assign wait_active = is_wait_state(cur);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .active   (wait_active),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur     <= S_IF;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (pc_write) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    // Outputs stay at their zero defaults while reset is asserted, which is
    // what aborts an in-flight instruction without a pc_write or reg_write.
    always_comb begin
        nxt          = cur;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_ctrl_sel = ALU_ADD;
        pc_source    = PC_SRC_PLUS4;
        wb_sel       = WB_ALUOUT;
        is_halted    = 1'b0;
        error        = 1'b0;
        if (reset) begin
            case (cur)
                S_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        nxt      = S_ID;
                    end else if (timeout) begin
                        nxt = S_ERR;
                    end
                end
                S_ID: begin
                    // ALUOut captures PC+imm for branch/JAL targets.
                    alu_src_a    = SRC_A_PC;
                    alu_src_b    = SRC_B_IMM;
                    alu_ctrl_sel = ALU_ADD;
                    case (opcode)
                        OP_R:               nxt = S_EX_R;
                        OP_IMM:             nxt = S_EX_I;
                        OP_LOAD, OP_STORE:  nxt = S_EX_ADDR;
                        OP_BRANCH:          nxt = S_EX_BR;
                        OP_JAL:             nxt = S_JAL;
                        OP_JALR:            nxt = S_JALR;
                        OP_LUI:             nxt = S_EX_LUI;
                        OP_AUIPC:           nxt = S_WB_ALU;
                        OP_SYSTEM: begin
                            if (halt_req) begin
                                nxt = S_HALT;
                            end else begin
                                pc_write  = 1'b1;
                                pc_source = PC_SRC_PLUS4;
                                nxt       = S_IF;
                            end
                        end
                        default:            nxt = S_ERR;
                    endcase
                end
                S_EX_R: begin
                    alu_src_a    = SRC_A_RS1;
                    alu_src_b    = SRC_B_RS2;
                    alu_ctrl_sel = ALU_FUNCT;
                    nxt          = S_WB_ALU;
                end
                S_EX_I: begin
                    alu_src_a    = SRC_A_RS1;
                    alu_src_b    = SRC_B_IMM;
                    alu_ctrl_sel = ALU_FUNCT;
                    nxt          = S_WB_ALU;
                end
                S_EX_LUI: begin
                    alu_src_a    = SRC_A_ZERO;
                    alu_src_b    = SRC_B_IMM;
                    alu_ctrl_sel = ALU_ADD;
                    nxt          = S_WB_ALU;
                end
                S_EX_ADDR: begin
                    alu_src_a    = SRC_A_RS1;
                    alu_src_b    = SRC_B_IMM;
                    alu_ctrl_sel = ALU_ADD;
                    nxt          = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_EX_BR: begin
                    alu_src_a    = SRC_A_RS1;
                    alu_src_b    = SRC_B_RS2;
                    alu_ctrl_sel = ALU_BRANCH;
                    pc_write     = 1'b1;
                    pc_source    = bcond ? PC_SRC_ALUOUT : PC_SRC_PLUS4;
                    nxt          = S_IF;
                end
                S_JAL: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_ALUOUT;
                    nxt       = S_IF;
                end
                S_JALR: begin
                    alu_src_a    = SRC_A_RS1;
                    alu_src_b    = SRC_B_IMM;
                    alu_ctrl_sel = ALU_ADD;
                    reg_write    = 1'b1;
                    wb_sel       = WB_PC4;
                    pc_write     = 1'b1;
                    pc_source    = PC_SRC_ALU;
                    nxt          = S_IF;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        nxt = S_WB_LD;
                    end else if (timeout) begin
                        nxt = S_ERR;
                    end
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        pc_write  = 1'b1;
                        pc_source = PC_SRC_PLUS4;
                        nxt       = S_IF;
                    end else if (timeout) begin
                        nxt = S_ERR;
                    end
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_ALUOUT;
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_PLUS4;
                    nxt       = S_IF;
                end
                S_WB_LD: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_MDR;
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_PLUS4;
                    nxt       = S_IF;
                end
                S_HALT: begin
                    is_halted = 1'b1;
                end
                S_ERR: begin
                    is_halted = 1'b1;
                    error     = 1'b1;
                end
                default: begin
                    nxt = S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The stimulus side computes, per
// instruction, the expected retirement (or terminal) record from the
// instruction class and memory latencies and queues it; the monitor pops
// a record whenever the DUT retires (pc_write) or halts (is_halted).
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int K_RET  = 0;
    localparam int K_HALT = 1;
    localparam int K_ERR  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [6:0]       opcode = '0;
    logic             bcond = 1'b0;
    logic             halt_req = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_read, mem_write, iord, ir_write, reg_write, pc_write;
    logic [1:0]       alu_src_a, alu_src_b, alu_ctrl_sel, pc_source, wb_sel;
    logic             is_halted, error;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .halt_req(halt_req), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .reg_write(reg_write), .pc_write(pc_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl_sel(alu_ctrl_sel),
        .pc_source(pc_source), .wb_sel(wb_sel), .is_halted(is_halted),
        .error(error), .state(state), .instret(instret)
    );

    typedef struct {
        int         kind;
        int         cycles;   // retire: cycles incl. retire cycle; terminal: cycles before it
        logic [1:0] ps;
        logic       rw;
        logic [1:0] wb;
        int         instret;
    } exp_t;

    exp_t       exq[$];
    logic [3:0] st_log[$];
    int         errors = 0;
    int         checks = 0;
    int         ret_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Reference model: instruction timing and retirement outputs from the
    // instruction class. wf/wm are the number of cycles mem_ready stays low
    // in fetch and in the data access.
    function automatic exp_t model(input logic [6:0] op, input logic bc, input logic hr,
                                   input int wf, input int wm);
        exp_t e;
        int   base;
        e.kind = K_RET; e.ps = 2'b00; e.rw = 1'b0; e.wb = 2'b00; e.instret = 0;
        if (wf >= MEM_TIMEOUT) begin
            e.kind = K_ERR; e.cycles = MEM_TIMEOUT;
            return e;
        end
        base = wf + 1 + 1;   // fetch + decode
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111: begin e.cycles = base + 2; e.rw = 1'b1; end
            7'b0010111: begin e.cycles = base + 1; e.rw = 1'b1; end
            7'b0000011: begin
                if (wm >= MEM_TIMEOUT) begin e.kind = K_ERR; e.cycles = base + 1 + MEM_TIMEOUT; end
                else begin e.cycles = base + 1 + wm + 1 + 1; e.rw = 1'b1; e.wb = 2'b01; end
            end
            7'b0100011: begin
                if (wm >= MEM_TIMEOUT) begin e.kind = K_ERR; e.cycles = base + 1 + MEM_TIMEOUT; end
                else e.cycles = base + 1 + wm + 1;
            end
            7'b1100011: begin e.cycles = base + 1; e.ps = bc ? 2'b01 : 2'b00; end
            7'b1101111: begin e.cycles = base + 1; e.rw = 1'b1; e.wb = 2'b10; e.ps = 2'b01; end
            7'b1100111: begin e.cycles = base + 1; e.rw = 1'b1; e.wb = 2'b10; e.ps = 2'b10; end
            7'b1110011: begin e.cycles = base; if (hr) e.kind = K_HALT; end
            default:    begin e.cycles = base; e.kind = K_ERR; end
        endcase
        return e;
    endfunction

    // Drives one instruction. abort_at >= 0 stops after that many cycles
    // without queuing an expectation (the caller then resets).
    task automatic run_instr(input logic [6:0] op, input logic bc, input logic hr,
                             input int wf, input int wm, input int abort_at, input bit log_st);
        exp_t e;
        int   n;
        bit   is_mem;
        e = model(op, bc, hr, wf, wm);
        is_mem = (op == 7'b0000011) || (op == 7'b0100011);
        if (abort_at >= 0) begin
            n = abort_at;
        end else begin
            e.instret = ret_cnt % (1 << CNT_W);
            exq.push_back(e);
            if (e.kind == K_RET) ret_cnt++;
            n = (e.kind == K_RET) ? e.cycles : e.cycles + 1;
        end
        st_log.delete();
        opcode = op; bcond = bc; halt_req = hr;
        for (int k = 0; k < n; k++) begin
            if (k < wf) mem_ready = 1'b0;
            else if (k == wf) mem_ready = 1'b1;
            else if (is_mem && k >= wf + 3 && k < wf + 3 + wm) mem_ready = 1'b0;
            else if (is_mem && k == wf + 3 + wm) mem_ready = 1'b1;
            else mem_ready = 1'($urandom % 2);   // must be ignored here
            #1;
            if (log_st) st_log.push_back(state);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_pc_write", 32'(pc_write), 0);
        check("rst_reg_write", 32'(reg_write), 0);
        check("rst_is_halted", 32'(is_halted), 0);
        check("rst_error", 32'(error), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        ret_cnt = 0;
        check("rst_state", 32'(state), 32'(S_IF));
        check("rst_instret", 32'(instret), 0);
    endtask

    // Monitor
    initial begin
        int   cnt;
        bit   halted_seen;
        exp_t e;
        cnt = 0; halted_seen = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0; halted_seen = 0;
            end else if (!halted_seen) begin
                cnt++;
                if (pc_write === 1'b1) begin
                    if (exq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_retire: got pc_write=1 expected no retirement");
                    end else begin
                        e = exq.pop_front();
                        check("retire_kind", K_RET, 32'(e.kind));
                        check("retire_cycles", 32'(cnt), 32'(e.cycles));
                        check("retire_pc_source", 32'(pc_source), 32'(e.ps));
                        check("retire_reg_write", 32'(reg_write), 32'(e.rw));
                        if (e.rw) check("retire_wb_sel", 32'(wb_sel), 32'(e.wb));
                        check("retire_instret", 32'(instret), 32'(e.instret));
                    end
                    cnt = 0;
                end else if (is_halted === 1'b1) begin
                    if (exq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_halt: got is_halted=1 expected running");
                    end else begin
                        e = exq.pop_front();
                        check("term_kind", error ? K_ERR : K_HALT, 32'(e.kind));
                        check("term_cycles", 32'(cnt - 1), 32'(e.cycles));
                    end
                    halted_seen = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops[10];
        logic [6:0] op;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

        do_reset();

        // add: IF, ID, EX_R, WB_ALU
        run_instr(7'b0110011, 1'b0, 1'b0, 0, 0, -1, 1);
        check("add_st0", 32'(st_log[0]), 32'(S_IF));
        check("add_st1", 32'(st_log[1]), 32'(S_ID));
        check("add_st2", 32'(st_log[2]), 32'(S_EX_R));
        check("add_st3", 32'(st_log[3]), 32'(S_WB_ALU));
        check("add_instret", 32'(instret), 1);

        // lw with data ready on the 3rd MEM_RD cycle, then both beq outcomes
        run_instr(7'b0000011, 1'b0, 1'b0, 0, 2, -1, 0);
        run_instr(7'b1100011, 1'b1, 1'b0, 0, 0, -1, 0);
        run_instr(7'b1100011, 1'b0, 1'b0, 0, 0, -1, 0);

        // fetch timeout
        run_instr(7'b0110011, 1'b0, 1'b0, 4, 0, -1, 1);
        check("tmo_st3", 32'(st_log[3]), 32'(S_IF));
        check("tmo_st4", 32'(st_log[4]), 32'(S_ERR));
        check("tmo_error", 32'(error), 1);
        check("tmo_is_halted", 32'(is_halted), 1);
        do_reset();

        // mem_ready on the last allowed wait cycle wins over the timeout
        run_instr(7'b0110011, 1'b0, 1'b0, 3, 0, -1, 1);
        check("prio_st4", 32'(st_log[4]), 32'(S_ID));

        // ecall with halt, held for 10 cycles under random inputs
        run_instr(7'b1110011, 1'b0, 1'b1, 0, 0, -1, 0);
        for (int i = 0; i < 10; i++) begin
            opcode = 7'($urandom); mem_ready = 1'($urandom % 2); bcond = 1'($urandom % 2);
            #1;
            check("halt_state", 32'(state), 32'(S_HALT));
            check("halt_flags", {30'd0, is_halted, error}, 32'b10);
            check("halt_pc_write", 32'(pc_write), 0);
            @(posedge clk); #1;
        end
        do_reset();

        // ecall without halt retires from ID; store data-phase timeout
        run_instr(7'b1110011, 1'b0, 1'b0, 1, 0, -1, 0);
        run_instr(7'b0100011, 1'b0, 1'b0, 0, 4, -1, 0);
        check("st_tmo_error", 32'(error), 1);
        do_reset();

        // illegal opcode
        run_instr(7'b1111111, 1'b0, 1'b0, 0, 0, -1, 0);
        check("bad_op_state", 32'(state), 32'(S_ERR));
        check("bad_op_error", 32'(error), 1);
        do_reset();

        // reset while a store waits in MEM_WR (mem_ready forced high in reset)
        run_instr(7'b0100011, 1'b0, 1'b0, 0, 3, 5, 0);
        check("abort_state", 32'(state), 32'(S_MEM_WR));
        do_reset();

        // 17 retirements wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            op = ops[$urandom_range(0, 9)];
            run_instr(op, 1'($urandom % 2), (op == 7'b1110011) ? 1'b0 : 1'($urandom % 2),
                      $urandom_range(0, 3), $urandom_range(0, 3), -1, 0);
        end
        check("wrap_instret", 32'(instret), 1);

        // further random retiring traffic
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            run_instr(op, 1'($urandom % 2), (op == 7'b1110011) ? 1'b0 : 1'($urandom % 2),
                      $urandom_range(0, 3), $urandom_range(0, 3), -1, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", 32'(exq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
